// File: rtl/stack_sequencer_if.sv
// Command/response bundle between the control unit and the stack sequencer.
// master = control unit (issues commands), slave = stack_sequencer.
interface stack_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_sequencer.sv
// Request-level front end for the byte-wide hardware stack.
// Accepts PUSH8/POP8/CALL/RET, bound-checks them against stk_sp at accept,
// expands them into single-cycle push/pop strobes and returns data or a fault.
// Optional build macro STACK_SEQ_WATERMARK_EN adds low_water and fault_cnt.
module stack_sequencer #(
  parameter int              SP_W     = 16,
  parameter logic [SP_W-1:0] LIMIT_LO = '0,
  parameter logic [SP_W-1:0] LIMIT_HI = '1
) (
  input  logic             clk,
  input  logic             reset,
  stack_sequencer_if.slave bus,
  output logic             stk_enable,
  output logic             stk_decrement,
  output logic             stk_increment,
  output logic [7:0]       stk_wdata,
  input  logic [7:0]       stk_rdata,
  input  logic [SP_W-1:0]  stk_sp
`ifdef STACK_SEQ_WATERMARK_EN
  ,
  output logic [SP_W-1:0]  low_water,
  output logic [7:0]       fault_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    POP_1,
    POP_2,
    POP_3,
    DONE
  } state_t;

  state_t      state;
  logic        two_q;
  logic [7:0]  data_lo_q;
  logic [7:0]  lo_q;

  logic        accept;
  logic        two_byte;
  logic        is_push;
  logic [SP_W:0] nbytes;
  logic        push_ok;
  logic        pop_ok;
  logic        legal;

  // Bound check on the request in flight; extended by one bit so the
  // comparisons never wrap at the ends of the address range.
  always_comb begin
    accept   = bus.req_valid & bus.req_ready;
    two_byte = bus.req_op[1];
    is_push  = ~bus.req_op[0];
    nbytes   = {{(SP_W-1){1'b0}}, two_byte, ~two_byte};
    push_ok  = {1'b0, stk_sp} >= ({1'b0, LIMIT_LO} + nbytes);
    pop_ok   = ({1'b0, stk_sp} + nbytes) <= {1'b0, LIMIT_HI};
    legal    = is_push ? push_ok : pop_ok;
  end

  // Command payload and first popped byte; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      two_q     <= two_byte;
      data_lo_q <= bus.req_data[7:0];
    end
    if (state == POP_2) lo_q <= stk_rdata;
  end

  // Sequencer FSM; strobes and response are registered together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      stk_enable    <= 1'b0;
      stk_decrement <= 1'b0;
      stk_increment <= 1'b0;
      stk_wdata     <= 8'h00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 16'h0000;
      bus.rsp_err   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.req_ready <= 1'b0;
            if (!legal) begin
              state         <= DONE;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= 16'h0000;
              bus.rsp_err   <= is_push ? 2'b01 : 2'b10;
            end else if (is_push) begin
              stk_enable    <= 1'b1;
              stk_decrement <= 1'b1;
              if (two_byte) begin
                state     <= PUSH_HI;
                stk_wdata <= bus.req_data[15:8];
              end else begin
                state     <= PUSH_LO;
                stk_wdata <= bus.req_data[7:0];
              end
            end else begin
              state         <= POP_1;
              stk_enable    <= 1'b1;
              stk_increment <= 1'b1;
            end
          end
        end
        PUSH_HI: begin
          state     <= PUSH_LO;
          stk_wdata <= data_lo_q;
        end
        PUSH_LO: begin
          state         <= DONE;
          stk_enable    <= 1'b0;
          stk_decrement <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= 16'h0000;
          bus.rsp_err   <= 2'b00;
        end
        POP_1: begin
          state <= POP_2;
          // RET keeps the pop strobe up for its second byte.
          if (!two_q) begin
            stk_enable    <= 1'b0;
            stk_increment <= 1'b0;
          end
        end
        POP_2: begin
          stk_enable    <= 1'b0;
          stk_increment <= 1'b0;
          if (two_q) begin
            state <= POP_3;
          end else begin
            state         <= DONE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= {8'h00, stk_rdata};
            bus.rsp_err   <= 2'b00;
          end
        end
        POP_3: begin
          state         <= DONE;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= {stk_rdata, lo_q};
          bus.rsp_err   <= 2'b00;
        end
        DONE: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          stk_enable    <= 1'b0;
          stk_decrement <= 1'b0;
          stk_increment <= 1'b0;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef STACK_SEQ_WATERMARK_EN
  logic [SP_W-1:0] sp_after_push;

  always_comb sp_after_push = stk_sp - SP_W'(1);

  // Track deepest push excursion and count fault responses (saturating).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_water <= LIMIT_HI;
      fault_cnt <= 8'h00;
    end else begin
      if (stk_enable && stk_decrement && (sp_after_push < low_water))
        low_water <= sp_after_push;
      if ((state == IDLE) && accept && !legal && (fault_cnt != 8'hFF))
        fault_cnt <= fault_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: table of single commands against a small
// byte-stack model, plus reset-abort and back-to-back sequences.
module tb_stack_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        stk_enable, stk_decrement, stk_increment;
  logic [7:0]  stk_wdata, stk_rdata;
  logic [15:0] stk_sp;
`ifdef STACK_SEQ_WATERMARK_EN
  logic [15:0] low_water;
  logic [7:0]  fault_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int proto_viol = 0;

  always #5 clk = ~clk;

  stack_sequencer_if bus();

  stack_sequencer #(.SP_W(16), .LIMIT_LO(16'h0000), .LIMIT_HI(16'hFFFF)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .stk_enable    (stk_enable),
    .stk_decrement (stk_decrement),
    .stk_increment (stk_increment),
    .stk_wdata     (stk_wdata),
    .stk_rdata     (stk_rdata),
    .stk_sp        (stk_sp)
`ifdef STACK_SEQ_WATERMARK_EN
    ,
    .low_water     (low_water),
    .fault_cnt     (fault_cnt)
`endif
  );

  // Byte stack model: push pre-decrements, pop reads then increments.
  logic [7:0]  mem [0:65535];
  logic        sp_load;
  logic [15:0] sp_new;

  always @(posedge clk) begin
    if (sp_load) stk_sp <= sp_new;
    else if (stk_enable && stk_decrement) begin
      mem[stk_sp - 16'd1] <= stk_wdata;
      stk_sp <= stk_sp - 16'd1;
    end else if (stk_enable && stk_increment) begin
      stk_rdata <= mem[stk_sp];
      stk_sp <= stk_sp + 16'd1;
    end
  end

  // Strobe legality: exactly one direction while enabled, none otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      if (stk_enable && (stk_decrement == stk_increment)) proto_viol++;
      if (!stk_enable && (stk_decrement || stk_increment)) proto_viol++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_sp(input logic [15:0] sp);
    @(negedge clk);
    sp_new  = sp;
    sp_load = 1'b1;
    @(negedge clk);
    sp_load = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] data, input logic [15:0] sp,
                         output int lat, output int ndec, output int ninc,
                         output logic [15:0] wlog, output logic [15:0] rdat,
                         output logic [1:0] err, output int span);
    int first, last;
    load_sp(sp);
    check("ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_data  = data;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1; ndec = 0; ninc = 0; wlog = 16'h0; rdat = 16'h0; err = 2'b0;
    first = 0; last = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (stk_enable) begin
        if (first == 0) first = k;
        last = k;
        if (stk_decrement) begin
          ndec++;
          wlog = {wlog[7:0], stk_wdata};
        end
        if (stk_increment) ninc++;
      end
      if (bus.rsp_valid) begin
        lat  = k;
        rdat = bus.rsp_data;
        err  = bus.rsp_err;
        break;
      end
    end
    span = (first == 0) ? 0 : last - first + 1;
    @(negedge clk);
    check("ready_after_rsp", 32'(bus.req_ready), 32'd1);
    check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] sp;
    logic [1:0]  err;
    logic [15:0] rdat;
    int          lat;
    int          ndec;
    int          ninc;
    logic [15:0] wlog;
  } vec_t;

  vec_t vt [12];

  initial begin
    int lat, ndec, ninc, span, acc, rsps, decs;
    logic [15:0] wlog, rdat;
    logic [1:0]  err;
    logic        prev_rsp;

    //             op     data      sp        err    rdat      lat ndec ninc wlog
    vt[0]  = '{2'b10, 16'h1234, 16'h0100, 2'b00, 16'h0000, 3, 2, 0, 16'h1234}; // CALL
    vt[1]  = '{2'b11, 16'h0000, 16'h00FE, 2'b00, 16'h1234, 4, 0, 2, 16'h0000}; // RET
    vt[2]  = '{2'b00, 16'h0011, 16'h0000, 2'b01, 16'h0000, 1, 0, 0, 16'h0000}; // PUSH8 overflow
    vt[3]  = '{2'b00, 16'h005A, 16'hFFFF, 2'b00, 16'h0000, 2, 1, 0, 16'h005A}; // PUSH8
    vt[4]  = '{2'b01, 16'h0000, 16'hFFFE, 2'b00, 16'h005A, 3, 0, 1, 16'h0000}; // POP8 at FFFE ok
    vt[5]  = '{2'b11, 16'h0000, 16'hFFFE, 2'b10, 16'h0000, 1, 0, 0, 16'h0000}; // RET underflow
    vt[6]  = '{2'b10, 16'h5555, 16'h0001, 2'b01, 16'h0000, 1, 0, 0, 16'h0000}; // CALL overflow
    vt[7]  = '{2'b10, 16'hABCD, 16'h0002, 2'b00, 16'h0000, 3, 2, 0, 16'hABCD}; // CALL at edge
    vt[8]  = '{2'b01, 16'h0000, 16'hFFFF, 2'b10, 16'h0000, 1, 0, 0, 16'h0000}; // POP8 underflow
    vt[9]  = '{2'b00, 16'h0077, 16'h0001, 2'b00, 16'h0000, 2, 1, 0, 16'h0077}; // PUSH8 at edge
    vt[10] = '{2'b01, 16'h0000, 16'h0000, 2'b00, 16'h0077, 3, 0, 1, 16'h0000}; // POP8
    vt[11] = '{2'b11, 16'h0000, 16'h0000, 2'b00, 16'hAB77, 4, 0, 2, 16'h0000}; // RET

    reset = 1'b1;
    sp_load = 1'b0;
    sp_new = 16'h0;
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.req_data = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_enable", 32'(stk_enable), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_wdata", 32'(stk_wdata), 32'd0);
`ifdef STACK_SEQ_WATERMARK_EN
    check("rst_low_water", 32'(low_water), 32'hFFFF);
    check("rst_fault_cnt", 32'(fault_cnt), 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_cmd(vt[i].op, vt[i].data, vt[i].sp, lat, ndec, ninc, wlog, rdat, err, span);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].err));
      check($sformatf("v%0d_data", i), 32'(rdat), 32'(vt[i].rdat));
      check($sformatf("v%0d_latency", i), lat, vt[i].lat);
      check($sformatf("v%0d_push_strobes", i), ndec, vt[i].ndec);
      check($sformatf("v%0d_pop_strobes", i), ninc, vt[i].ninc);
      check($sformatf("v%0d_wdata", i), 32'(wlog), 32'(vt[i].wlog));
      check($sformatf("v%0d_strobe_span", i), span, vt[i].ndec + vt[i].ninc);
    end
`ifdef STACK_SEQ_WATERMARK_EN
    check("tbl_low_water", 32'(low_water), 32'h0000);
    check("tbl_fault_cnt", 32'(fault_cnt), 32'd4);
`endif

    // Reset while a RET sits in POP_2 with its second pop strobe up.
    load_sp(16'h0100);
    bus.req_valid = 1'b1;
    bus.req_op = 2'b11;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_pop2_strobe", 32'(stk_increment & stk_enable), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_enable", 32'(stk_enable), 32'd0);
    check("abort_increment", 32'(stk_increment), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    rsps = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) rsps++;
    end
    check("abort_no_rsp", rsps, 0);
    check("abort_ready_after", 32'(bus.req_ready), 32'd1);
    run_cmd(2'b00, 16'h00A5, 16'h0100, lat, ndec, ninc, wlog, rdat, err, span);
    check("post_abort_err", 32'(err), 32'd0);
    check("post_abort_latency", lat, 2);
    check("post_abort_wdata", 32'(wlog), 32'h00A5);
    check("post_abort_push_strobes", ndec, 1);

    // Back-to-back PUSH8 with req_valid held high for 12 cycles.
    load_sp(16'h0080);
    bus.req_op = 2'b00;
    bus.req_data = 16'h00C3;
    bus.req_valid = 1'b1;
    acc = 0; rsps = 0; decs = 0; prev_rsp = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.req_ready && bus.req_valid) acc++;
      if (stk_enable && stk_decrement) decs++;
      if (bus.rsp_valid) rsps++;
      if (prev_rsp) check("b2b_ready_after_rsp", 32'(bus.req_ready), 32'd1);
      prev_rsp = bus.rsp_valid;
      if (k == 11) bus.req_valid = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("b2b_accepts", acc, 4);
    check("b2b_responses", rsps, 4);
    check("b2b_push_strobes", decs, 4);
    check("b2b_final_sp", 32'(stk_sp), 32'h007C);
`ifdef STACK_SEQ_WATERMARK_EN
    check("b2b_low_water", 32'(low_water), 32'h007C);
    check("b2b_fault_cnt", 32'(fault_cnt), 32'd0);
`endif

    check("strobe_protocol_violations", proto_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
